// File: rtl/slc3_mem_arbiter.sv
// Two-port round-robin arbiter that sequences single-port SLC-3 BRAM accesses with fixed wait states.
// Optional memory-mapped I/O at the all-ones address is enabled by defining SLC3_MMIO_EN.
module slc3_mem_arbiter #(
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              grant0_o,
    output logic              grant1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
`ifdef SLC3_MMIO_EN
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] hex_o,
`endif
    output logic              bram_ena_o,
    output logic              bram_wea_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    input  logic [DATA_W-1:0] bram_dout_i
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                winner_q, winner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                pick1;
    logic                mmio_hit;

`ifdef SLC3_MMIO_EN
    logic [DATA_W-1:0]   hex_q, hex_d;
    assign mmio_hit = (addr_q == {ADDR_W{1'b1}});
    assign hex_o    = hex_q;
`else
    assign mmio_hit = 1'b0;
`endif

    // State register; the latched request fields are reset too so the BRAM bus idles at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
`ifdef SLC3_MMIO_EN
            hex_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
`ifdef SLC3_MMIO_EN
            hex_q        <= hex_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        pick1        = 1'b0;
`ifdef SLC3_MMIO_EN
        hex_d        = hex_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    // Under contention the port that did not win last time goes first.
                    pick1        = (req0_i && req1_i) ? ~last_grant_q : req1_i;
                    winner_d     = pick1;
                    last_grant_d = pick1;
                    we_d         = pick1 ? we1_i    : we0_i;
                    addr_d       = pick1 ? addr1_i  : addr0_i;
                    wdata_d      = pick1 ? wdata1_i : wdata0_i;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q || mmio_hit) begin
`ifdef SLC3_MMIO_EN
                    if (mmio_hit) begin
                        if (we_q) hex_d   = wdata_q;
                        else      rdata_d = sw_i;
                    end
`endif
                    state_d = S_DONE;
                end else if (READ_LAT == 1) begin
                    rdata_d = bram_dout_i;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bram_dout_i;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        grant0_o    = busy_o & ~winner_q;
        grant1_o    = busy_o &  winner_q;
        done0_o     = (state_q == S_DONE) & ~winner_q;
        done1_o     = (state_q == S_DONE) &  winner_q;
        rdata_o     = rdata_q;
        bram_ena_o  = (state_q == S_ISSUE) & ~mmio_hit;
        bram_wea_o  = bram_ena_o & we_q;
        bram_addr_o = bram_ena_o ? addr_q  : '0;
        bram_din_o  = bram_ena_o ? wdata_q : '0;
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench for slc3_mem_arbiter: instance A uses READ_LAT=2, instance B uses READ_LAT=3.
// Each instance drives its own behavioural BRAM model with matching read latency.
module tb_slc3_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A signals (READ_LAT = 2)
    logic [1:0]  a_req, a_we, a_grant, a_done;
    logic [15:0] a_addr [2];
    logic [15:0] a_wdata [2];
    logic [15:0] a_rdata, a_baddr, a_bdin, a_bdout;
    logic        a_busy, a_ena, a_wea;
    // Instance B signals (READ_LAT = 3)
    logic [1:0]  b_req, b_we, b_grant, b_done;
    logic [15:0] b_addr [2];
    logic [15:0] b_wdata [2];
    logic [15:0] b_rdata, b_baddr, b_bdin, b_bdout;
    logic        b_busy, b_ena, b_wea;
`ifdef SLC3_MMIO_EN
    logic [15:0] a_sw, a_hex, b_sw, b_hex;
`endif

    slc3_mem_arbiter #(.READ_LAT(2), .ADDR_W(16), .DATA_W(16)) u_a (
        .clk_i(clk), .reset_i(reset),
        .req0_i(a_req[0]), .req1_i(a_req[1]), .we0_i(a_we[0]), .we1_i(a_we[1]),
        .addr0_i(a_addr[0]), .addr1_i(a_addr[1]), .wdata0_i(a_wdata[0]), .wdata1_i(a_wdata[1]),
        .grant0_o(a_grant[0]), .grant1_o(a_grant[1]), .done0_o(a_done[0]), .done1_o(a_done[1]),
        .rdata_o(a_rdata), .busy_o(a_busy),
`ifdef SLC3_MMIO_EN
        .sw_i(a_sw), .hex_o(a_hex),
`endif
        .bram_ena_o(a_ena), .bram_wea_o(a_wea), .bram_addr_o(a_baddr), .bram_din_o(a_bdin),
        .bram_dout_i(a_bdout)
    );

    slc3_mem_arbiter #(.READ_LAT(3), .ADDR_W(16), .DATA_W(16)) u_b (
        .clk_i(clk), .reset_i(reset),
        .req0_i(b_req[0]), .req1_i(b_req[1]), .we0_i(b_we[0]), .we1_i(b_we[1]),
        .addr0_i(b_addr[0]), .addr1_i(b_addr[1]), .wdata0_i(b_wdata[0]), .wdata1_i(b_wdata[1]),
        .grant0_o(b_grant[0]), .grant1_o(b_grant[1]), .done0_o(b_done[0]), .done1_o(b_done[1]),
        .rdata_o(b_rdata), .busy_o(b_busy),
`ifdef SLC3_MMIO_EN
        .sw_i(b_sw), .hex_o(b_hex),
`endif
        .bram_ena_o(b_ena), .bram_wea_o(b_wea), .bram_addr_o(b_baddr), .bram_din_o(b_bdin),
        .bram_dout_i(b_bdout)
    );

    // Behavioural BRAMs: registered read plus output register(s); preload port used during reset.
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic [15:0] a_p1, b_p1, b_p2;
    logic        pre_en_a, pre_en_b;
    logic [15:0] pre_addr, pre_data;

    always @(posedge clk) begin
        if (pre_en_a)              mem_a[pre_addr] <= pre_data;
        else if (a_ena && a_wea)   mem_a[a_baddr]  <= a_bdin;
        if (a_ena) a_p1 <= mem_a[a_baddr];
        a_bdout <= a_p1;
    end

    always @(posedge clk) begin
        if (pre_en_b)              mem_b[pre_addr] <= pre_data;
        else if (b_ena && b_wea)   mem_b[b_baddr]  <= b_bdin;
        if (b_ena) b_p1 <= mem_b[b_baddr];
        b_p2    <= b_p1;
        b_bdout <= b_p2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access: request in cycle 0, done expected exactly in cycle done_cyc.
    task automatic access(input int inst, input int port, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input int done_cyc, input logic exp_ena,
                          input logic chk_rd, input logic [15:0] exp_rd, input string tag);
        logic [1:0]  g, d;
        logic        ena, wea, busy;
        logic [15:0] rd, baddr, bdin;
        if (inst == 0) begin
            a_req[port] = 1'b1; a_we[port] = we; a_addr[port] = addr; a_wdata[port] = wdata;
        end else begin
            b_req[port] = 1'b1; b_we[port] = we; b_addr[port] = addr; b_wdata[port] = wdata;
        end
        for (int c = 1; c <= done_cyc; c++) begin
            step();
            if (inst == 0) begin
                g = a_grant; d = a_done; ena = a_ena; wea = a_wea; rd = a_rdata; baddr = a_baddr; bdin = a_bdin;
            end else begin
                g = b_grant; d = b_done; ena = b_ena; wea = b_wea; rd = b_rdata; baddr = b_baddr; bdin = b_bdin;
            end
            check({tag, " grant"}, {30'd0, g}, (port == 0) ? 32'd1 : 32'd2);
            check({tag, " done"}, {30'd0, d}, (c == done_cyc) ? ((port == 0) ? 32'd1 : 32'd2) : 32'd0);
            if (c == 1) begin
                check({tag, " ena"}, {31'd0, ena}, {31'd0, exp_ena});
                if (exp_ena) begin
                    check({tag, " wea"}, {31'd0, wea}, {31'd0, we});
                    check({tag, " addr"}, {16'd0, baddr}, {16'd0, addr});
                    if (we) check({tag, " din"}, {16'd0, bdin}, {16'd0, wdata});
                end
            end else begin
                check({tag, " ena idle"}, {31'd0, ena}, 32'd0);
            end
            if (c == done_cyc && chk_rd) check({tag, " rdata"}, {16'd0, rd}, {16'd0, exp_rd});
        end
        if (inst == 0) a_req[port] = 1'b0;
        else           b_req[port] = 1'b0;
        step();
        busy = (inst == 0) ? a_busy : b_busy;
        check({tag, " idle after"}, {31'd0, busy}, 32'd0);
    endtask

    int        owners [$];
    int        both_hot;

    initial begin
        reset = 1'b1;
        a_req = '0; a_we = '0; b_req = '0; b_we = '0;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; b_addr[i] = '0; b_wdata[i] = '0;
        end
`ifdef SLC3_MMIO_EN
        a_sw = '0; b_sw = '0;
`endif
        pre_en_a = 1'b1; pre_en_b = 1'b0; pre_addr = 16'h0010; pre_data = 16'h1234;
        step();
        pre_en_a = 1'b0; pre_en_b = 1'b1; pre_addr = 16'h0001; pre_data = 16'h0F0F;
        step();
        pre_en_b = 1'b0;
        step();

        // Reset state
        check("rst busy", {31'd0, a_busy}, 32'd0);
        check("rst grant", {30'd0, a_grant}, 32'd0);
        check("rst done", {30'd0, a_done}, 32'd0);
        check("rst rdata", {16'd0, a_rdata}, 32'd0);
        check("rst ena", {31'd0, a_ena}, 32'd0);
        check("rst addr", {16'd0, a_baddr}, 32'd0);
`ifdef SLC3_MMIO_EN
        check("rst hex", {16'd0, a_hex}, 32'd0);
`endif
        reset = 1'b0;

        // 1: read 0x0010 on port 0, done in cycle 4
        access(0, 0, 1'b0, 16'h0010, 16'h0000, 4, 1'b1, 1'b1, 16'h1234, "t1 rd");
        check("t1 rdata held", {16'd0, a_rdata}, 32'h1234);

        // 2: port 1 write then port 0 read-back
        access(0, 1, 1'b1, 16'h0020, 16'hBEEF, 2, 1'b1, 1'b0, 16'h0000, "t2 wr");
        check("t2 rdata held", {16'd0, a_rdata}, 32'h1234);
        access(0, 0, 1'b0, 16'h0020, 16'h0000, 4, 1'b1, 1'b1, 16'hBEEF, "t2 rd");

        // 3: contention right after reset alternates 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 2'b11; a_we = 2'b11;
        a_addr[0] = 16'h0100; a_wdata[0] = 16'h1111;
        a_addr[1] = 16'h0200; a_wdata[1] = 16'h2222;
        both_hot = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (a_grant == 2'b11) both_hot++;
            if (a_ena) owners.push_back(a_grant[1] ? 1 : 0);
        end
        a_req = 2'b00;
        step();
        check("t3 both granted", both_hot, 0);
        check("t3 issue count", owners.size(), 4);
        if (owners.size() == 4) begin
            check("t3 owner0", owners[0], 0);
            check("t3 owner1", owners[1], 1);
            check("t3 owner2", owners[2], 0);
            check("t3 owner3", owners[3], 1);
        end
        check("t3 idle", {31'd0, a_busy}, 32'd0);

        // 4: reset during WAIT abandons the read
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 16'h0010;
        step();
        check("t4 issue", {31'd0, a_ena}, 32'd1);
        step();
        check("t4 in wait", {31'd0, a_busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4 busy", {31'd0, a_busy}, 32'd0);
        check("t4 done", {30'd0, a_done}, 32'd0);
        check("t4 ena", {31'd0, a_ena}, 32'd0);
        check("t4 grant", {30'd0, a_grant}, 32'd0);
        check("t4 rdata", {16'd0, a_rdata}, 32'd0);
        access(0, 0, 1'b0, 16'h0010, 16'h0000, 4, 1'b1, 1'b1, 16'h1234, "t4 rd");

        // 5: top address, either MMIO or an ordinary BRAM location
`ifdef SLC3_MMIO_EN
        access(0, 0, 1'b1, 16'hFFFF, 16'h00A5, 2, 1'b0, 1'b0, 16'h0000, "t5 hex wr");
        check("t5 hex", {16'd0, a_hex}, 32'h00A5);
        a_sw = 16'h3C3C;
        access(0, 1, 1'b0, 16'hFFFF, 16'h0000, 2, 1'b0, 1'b1, 16'h3C3C, "t5 sw rd");
        check("t5 hex held", {16'd0, a_hex}, 32'h00A5);
`else
        access(0, 1, 1'b1, 16'hFFFF, 16'h5A5A, 2, 1'b1, 1'b0, 16'h0000, "t5 top wr");
        access(0, 0, 1'b0, 16'hFFFF, 16'h0000, 4, 1'b1, 1'b1, 16'h5A5A, "t5 top rd");
`endif

        // 6: READ_LAT=3 instance: read done in cycle 5, write in cycle 2
        access(1, 0, 1'b0, 16'h0001, 16'h0000, 5, 1'b1, 1'b1, 16'h0F0F, "t6 rd");
        access(1, 1, 1'b1, 16'h0003, 16'h7777, 2, 1'b1, 1'b0, 16'h0000, "t6 wr");
        access(1, 0, 1'b0, 16'h0003, 16'h0000, 5, 1'b1, 1'b1, 16'h7777, "t6 rd back");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
